// File: rtl/mouse_pkg.sv
// mouse_pkg: shared screen geometry, report byte bit positions and decoder FSM states
package mouse_pkg;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int BTN_LEFT = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_MID = 2;
    localparam int TOGGLE_BIT = 7;
    typedef enum logic [1:0] {PRIME, IDLE, LATCH, APPLY} state_t;
endpackage

// File: rtl/mouse_report_decoder_if.sv
// mouse_report_decoder_if: shot event valid/ready channel with captured cursor coordinates
interface mouse_report_decoder_if;
    logic shot_valid;
    logic shot_ready;
    logic [9:0] shot_x;
    logic [9:0] shot_y;
    modport master (output shot_valid, output shot_x, output shot_y, input shot_ready);
    modport slave (input shot_valid, input shot_x, input shot_y, output shot_ready);
endinterface

// File: rtl/axis_accum.sv
// axis_accum: adds a signed 8-bit delta to a 10-bit position and clamps to 0..LIMIT-1
module axis_accum #(
    parameter int LIMIT = 640
) (
    input  logic [9:0]        pos,
    input  logic signed [7:0] delta,
    output logic [9:0]        result
);
    localparam logic signed [11:0] MAX = 12'(LIMIT - 1);
    logic signed [11:0] sum;
    // widen both operands so the sum can go below zero or past the screen edge
    always_comb begin
        sum = $signed({2'b00, pos}) + $signed({{4{delta[7]}}, delta});
        result = sum < 12'sd0 ? 10'd0 : sum > MAX ? MAX[9:0] : sum[9:0];
    end
endmodule

// File: rtl/mouse_report_decoder.sv
// mouse_report_decoder: turns PIO mouse reports into a clamped cursor and rate-limited shot events
module mouse_report_decoder #(
    parameter int SCREEN_W = mouse_pkg::SCREEN_W,
    parameter int SCREEN_H = mouse_pkg::SCREEN_H,
    parameter int RESET_X = 320,
    parameter int RESET_Y = 240,
    parameter int HOLDOFF_CYCLES = 2500000
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [7:0]  MouseX,
    input  logic [7:0]  MouseY,
    input  logic [7:0]  MouseButtons,
    input  logic        shot_enable,
    mouse_report_decoder_if.master shot,
    output logic [9:0]  cursor_x,
    output logic [9:0]  cursor_y,
    output logic [2:0]  buttons,
    output logic        report_strobe,
    output logic [7:0]  dropped_count,
    output logic [15:0] report_count
);
    import mouse_pkg::*;
    state_t state, state_next;
    logic tog_q, load_tog, latch_en, apply_en;
    logic signed [7:0] dx, dy;
    logic [2:0] btn;
    logic [31:0] holdoff;
    logic [9:0] nx, ny;
    logic fire, press, blocked, pending, raise;
    logic unused_bits;
    assign unused_bits = ^MouseButtons[6:3];
    axis_accum #(.LIMIT(SCREEN_W)) u_x (.pos(cursor_x), .delta(dx), .result(nx));
    axis_accum #(.LIMIT(SCREEN_H)) u_y (.pos(cursor_y), .delta(dy), .result(ny));
    // state register
    always_ff @(posedge Clk)
        state <= !Reset_n ? PRIME : state_next;
    // next state: a toggle mismatch in IDLE starts the latch/apply sequence
    always_comb
        state_next = state == PRIME ? IDLE :
                     state == IDLE ? (MouseButtons[TOGGLE_BIT] != tog_q ? LATCH : IDLE) :
                     state == LATCH ? APPLY : IDLE;
    // per-state strobes
    always_comb begin
        load_tog = state == PRIME || state == LATCH;
        latch_en = state == LATCH;
        apply_en = state == APPLY;
    end
    // shot decision; a handshake in the same cycle frees the slot but restarts holdoff first
    always_comb begin
        fire = shot.shot_valid && shot.shot_ready;
        press = apply_en && btn[BTN_LEFT] && !buttons[BTN_LEFT];
        blocked = !shot_enable || (fire ? HOLDOFF_CYCLES != 0 : holdoff != 32'd0);
        pending = shot.shot_valid && !fire;
        raise = press && !blocked;
    end
    // report capture and cursor update
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            tog_q <= 1'b0;
            dx <= '0;
            dy <= '0;
            btn <= '0;
            cursor_x <= 10'(RESET_X);
            cursor_y <= 10'(RESET_Y);
            buttons <= '0;
            report_strobe <= 1'b0;
            report_count <= '0;
        end else begin
            if (load_tog) tog_q <= MouseButtons[TOGGLE_BIT];
            if (latch_en) begin
                dx <= MouseX;
                dy <= MouseY;
                btn <= MouseButtons[BTN_MID:BTN_LEFT];
            end
            report_strobe <= apply_en;
            if (apply_en) begin
                cursor_x <= nx;
                cursor_y <= ny;
                buttons <= btn;
                report_count <= report_count + 16'd1;
            end
        end
    end
    // shot channel, holdoff timer and dropped-press counter
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            shot.shot_valid <= 1'b0;
            shot.shot_x <= '0;
            shot.shot_y <= '0;
            holdoff <= '0;
            dropped_count <= '0;
        end else begin
            holdoff <= fire ? 32'(HOLDOFF_CYCLES) : holdoff != 32'd0 ? holdoff - 32'd1 : holdoff;
            shot.shot_valid <= raise || pending;
            if (raise && !pending) begin
                shot.shot_x <= nx;
                shot.shot_y <= ny;
            end
            if (raise && pending && dropped_count != 8'hFF) dropped_count <= dropped_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_mouse_report_decoder.sv
// tb_mouse_report_decoder: directed and random reports checked against a report-level model
module tb_mouse_report_decoder;
    localparam int HOLD = 100;
    logic Clk = 1'b0, Reset_n = 1'b0, shot_enable = 1'b0;
    logic [7:0] MouseX = '0, MouseY = '0, MouseButtons = '0;
    logic [9:0] cursor_x, cursor_y;
    logic [2:0] buttons;
    logic report_strobe;
    logic [7:0] dropped_count;
    logic [15:0] report_count;
    mouse_report_decoder_if shot_bus ();
    mouse_report_decoder #(.HOLDOFF_CYCLES(HOLD)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .MouseX(MouseX), .MouseY(MouseY),
        .MouseButtons(MouseButtons), .shot_enable(shot_enable), .shot(shot_bus),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .buttons(buttons),
        .report_strobe(report_strobe), .dropped_count(dropped_count), .report_count(report_count)
    );
    always #5 Clk = ~Clk;
    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;
    int checks = 0, errors = 0;
    int mx, my, m_sx, m_sy, m_drop, m_rc, acc_cyc;
    bit m_valid, have_acc, tog;
    logic [2:0] m_btn;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return v < lo ? lo : v > hi ? hi : v;
    endfunction

    task automatic model_reset();
        mx = 320; my = 240; m_btn = 0; m_valid = 0; m_sx = 0; m_sy = 0;
        m_drop = 0; m_rc = 0; have_acc = 0;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_cx"}, 32'(cursor_x), mx);
        chk({tag, "_cy"}, 32'(cursor_y), my);
        chk({tag, "_btn"}, 32'(buttons), 32'(m_btn));
        chk({tag, "_rc"}, 32'(report_count), m_rc);
        chk({tag, "_sv"}, 32'(shot_bus.shot_valid), 32'(m_valid));
        chk({tag, "_sx"}, 32'(shot_bus.shot_x), m_sx);
        chk({tag, "_sy"}, 32'(shot_bus.shot_y), m_sy);
        chk({tag, "_drop"}, 32'(dropped_count), m_drop);
    endtask

    task automatic send_report(input int dx, input int dy, input logic [2:0] b);
        bit press;
        @(negedge Clk);
        MouseX = 8'(dx);
        MouseY = 8'(dy);
        tog = ~tog;
        MouseButtons = {tog, 4'($urandom), b};
        @(posedge Clk); #1 chk("strobe_e1", 32'(report_strobe), 0);
        @(posedge Clk); #1 chk("strobe_e2", 32'(report_strobe), 0);
        @(posedge Clk); #1;
        mx = clampi(mx + dx, 0, 639);
        my = clampi(my + dy, 0, 479);
        press = b[0] && !m_btn[0];
        m_btn = b;
        m_rc = (m_rc + 1) % 65536;
        if (press && shot_enable && !(have_acc && cyc - acc_cyc <= HOLD)) begin
            if (m_valid) m_drop = m_drop < 255 ? m_drop + 1 : 255;
            else begin
                m_valid = 1; m_sx = mx; m_sy = my;
            end
        end
        chk("strobe_e3", 32'(report_strobe), 1);
        chk_all("apply");
        @(posedge Clk); #1 chk("strobe_e4", 32'(report_strobe), 0);
    endtask

    task automatic go_to(input int tx, input int ty);
        while (mx != tx || my != ty)
            send_report(clampi(tx - mx, -128, 127), clampi(ty - my, -128, 127), 3'b000);
    endtask

    task automatic accept();
        @(negedge Clk);
        shot_bus.shot_ready = 1'b1;
        @(posedge Clk); #1;
        if (m_valid) begin
            m_valid = 0; acc_cyc = cyc; have_acc = 1;
        end
        chk("accept_sv", 32'(shot_bus.shot_valid), 32'(m_valid));
        @(negedge Clk);
        shot_bus.shot_ready = 1'b0;
    endtask

    initial begin
        shot_bus.shot_ready = 1'b0;
        tog = 0;
        model_reset();
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_strobe", 32'(report_strobe), 0);
        chk_all("rst");
        @(negedge Clk) Reset_n = 1'b1;
        repeat (2) @(posedge Clk);
        // basic report and its latency
        send_report(10, -20, 3'b000);
        chk("first_cx", 32'(cursor_x), 330);
        chk("first_cy", 32'(cursor_y), 220);
        // clamp boundaries
        go_to(5, 470);
        send_report(-128, 127, 3'b000);
        chk("clamp_lo_x", 32'(cursor_x), 0);
        chk("clamp_hi_y", 32'(cursor_y), 479);
        go_to(630, 479);
        send_report(127, 0, 3'b000);
        chk("clamp_hi_x", 32'(cursor_x), 639);
        // shot raise, hold and drop
        shot_enable = 1'b1;
        go_to(100, 50);
        send_report(0, 0, 3'b001);
        chk("shot_raise_v", 32'(shot_bus.shot_valid), 1);
        chk("shot_raise_x", 32'(shot_bus.shot_x), 100);
        chk("shot_raise_y", 32'(shot_bus.shot_y), 50);
        for (int i = 0; i < 5; i++) begin
            repeat (10) @(posedge Clk);
            #1 chk("shot_hold", 32'(shot_bus.shot_valid), 1);
        end
        send_report(0, 0, 3'b000);
        send_report(3, 4, 3'b001);
        chk("drop_one", 32'(dropped_count), 1);
        chk("drop_keep_x", 32'(shot_bus.shot_x), 100);
        // accept then holdoff
        accept();
        chk("accepted", 32'(shot_bus.shot_valid), 0);
        send_report(0, 0, 3'b000);
        repeat (30) @(posedge Clk);
        send_report(0, 0, 3'b001);
        chk("holdoff_ignored", 32'(shot_bus.shot_valid), 0);
        chk("holdoff_nodrop", 32'(dropped_count), 1);
        send_report(0, 0, 3'b000);
        repeat (120) @(posedge Clk);
        send_report(-7, 9, 3'b001);
        chk("after_holdoff", 32'(shot_bus.shot_valid), 1);
        accept();
        // enable gating and no-edge hold
        repeat (HOLD + 5) @(posedge Clk);
        shot_enable = 1'b0;
        send_report(1, 1, 3'b000);
        send_report(1, 1, 3'b001);
        chk("disabled_press", 32'(shot_bus.shot_valid), 0);
        shot_enable = 1'b1;
        send_report(1, 1, 3'b111);
        chk("no_edge", 32'(shot_bus.shot_valid), 0);
        // random reports with occasional acceptance
        for (int i = 0; i < 40; i++) begin
            shot_enable = ($urandom % 4) != 0;
            send_report(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                        3'($urandom));
            if ($urandom % 3 == 0) accept();
            repeat ($urandom % 5) @(posedge Clk);
        end
        // reset in LATCH with a shot pending
        shot_enable = 1'b1;
        repeat (HOLD + 5) @(posedge Clk);
        send_report(0, 0, 3'b000);
        send_report(0, 0, 3'b001);
        chk("pre_reset_pending", 32'(shot_bus.shot_valid), 1);
        @(negedge Clk);
        tog = ~tog;
        MouseButtons = {tog, 7'b0000001};
        @(posedge Clk);
        @(negedge Clk) Reset_n = 1'b0;
        @(posedge Clk); #1;
        model_reset();
        chk("mid_rst_strobe", 32'(report_strobe), 0);
        chk_all("mid_rst");
        @(negedge Clk);
        tog = 1;
        MouseButtons = 8'h80;
        Reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk); #1;
            chk("prime_no_strobe", 32'(report_strobe), 0);
        end
        chk("prime_rc", 32'(report_count), 0);
        send_report(2, 3, 3'b000);
        chk("post_prime_cx", 32'(cursor_x), 322);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
